// File: rtl/conf_regs_writer.sv
// -----------------------------------------------------------------------------
// conf_regs_writer
//
// Initiator end of the Simple Interface (SI) register-write bus. Host command
// frames arrive one byte at a time from the RX side of the USB/FIFO bridge:
// an address byte followed by DATA_WIDTH/8 data bytes, most significant byte
// first. Once a frame is complete the block presents it on the SI bus and
// holds it until the register bank acknowledges, then accepts the next frame.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   rx_data[7:0]   host byte
//   rx_rdy         rx_data valid
//   rx_ack         registered one-cycle pulse: byte sampled on the previous
//                  edge has been consumed
//   register_addr  SI address (LSBs of the address byte)
//   register_data  SI data (assembled big-endian from the data bytes)
//   register_rdy   SI write request, held until register_ack
//   register_ack   SI acknowledge from the register bank
//   busy           frame partially received or write pending
//   err_timeout    one-cycle pulse: write abandoned, no ack within
//                  TIMEOUT_CYCLES (timeout build only, otherwise tied 0)
//
// Build option
//   CONF_REGS_WRITER_TIMEOUT_EN  when defined, a write that sees no ack for
//                                TIMEOUT_CYCLES cycles of register_rdy is
//                                abandoned and err_timeout pulses. When not
//                                defined, a write to an address nobody decodes
//                                stalls the writer until reset.
// -----------------------------------------------------------------------------
module conf_regs_writer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_ack,
    output logic [ADDR_WIDTH-1:0] register_addr,
    output logic [DATA_WIDTH-1:0] register_data,
    output logic                  register_rdy,
    input  logic                  register_ack,
    output logic                  busy,
    output logic                  err_timeout
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);

    // Configurations the datapath cannot represent leave this marker scope in
    // the elaborated hierarchy so a bad instance is easy to spot.
    generate
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8 || DATA_WIDTH < 8 ||
            (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_unsupported_params
        end
    endgenerate

    typedef enum logic [1:0] {
        GET_ADDR = 2'd0,
        GET_DATA = 2'd1,
        WRITE    = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic                    rx_ack_q, rx_ack_d;
    logic                    rdy_q,    rdy_d;
    logic                    busy_q,   busy_d;

`ifdef CONF_REGS_WRITER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // The counter is compared before it increments, so matching
    // TIMEOUT_CYCLES-1 here means "this cycle brings it to TIMEOUT_CYCLES"
    // and register_rdy stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0]        tmo_q,    tmo_d;
    logic                    err_q,    err_d;
`endif

    // A byte is consumable only when the previous edge did not already take
    // one: rx_ack is registered, so upstream cannot have advanced yet and the
    // same byte is still on rx_data.
    logic take_byte;
    assign take_byte = rx_rdy && !rx_ack_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned;
        // a missing default here would infer a latch. Blocking assignments are
        // correct in combinational blocks.
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rx_ack_d = 1'b0;
        rdy_d    = rdy_q;
`ifdef CONF_REGS_WRITER_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = 1'b0;
`endif

        unique case (state_q)
            GET_ADDR: begin
                if (take_byte) begin
                    addr_d   = rx_data[ADDR_WIDTH-1:0];
                    cnt_d    = '0;
                    rx_ack_d = 1'b1;
                    state_d  = GET_DATA;
                end
            end

            GET_DATA: begin
                if (take_byte) begin
                    // Shift in from the LSB side so the first data byte ends
                    // up most significant once all bytes have arrived.
                    data_d   = (data_q << 8) | DATA_WIDTH'(rx_data);
                    cnt_d    = cnt_q + CNT_W'(1);
                    rx_ack_d = 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                // First WRITE cycle: the last data byte's rx_ack is on the
                // wire and register_rdy is still low. Any ack seen now is
                // stray and ignored.
                if (!rdy_q) begin
                    rdy_d = 1'b1;
`ifdef CONF_REGS_WRITER_TIMEOUT_EN
                    tmo_d = '0;
`endif
                end else if (register_ack) begin
                    // Checked ahead of the timeout: an ack on the expiry
                    // cycle is a successful write.
                    rdy_d   = 1'b0;
                    state_d = GET_ADDR;
                end
`ifdef CONF_REGS_WRITER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rdy_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = GET_ADDR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end

            default: begin
                state_d = GET_ADDR;
                rdy_d   = 1'b0;
            end
        endcase

        // register_rdy is only ever high in WRITE, so looking at the next
        // state alone covers both halves of the busy definition.
        busy_d = (state_d != GET_ADDR);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register here, including the address/data
            // holding registers, is reset: the bus outputs must read 0 while
            // rst is low, and there is no RAM whose contents could be left
            // unreset.
            state_q  <= GET_ADDR;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rx_ack_q <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CONF_REGS_WRITER_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rx_ack_q <= rx_ack_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
`ifdef CONF_REGS_WRITER_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -------------------------------------------------------------------------
    assign rx_ack        = rx_ack_q;
    assign register_addr = addr_q;
    assign register_data = data_q;
    assign register_rdy  = rdy_q;
    assign busy          = busy_q;

`ifdef CONF_REGS_WRITER_TIMEOUT_EN
    assign err_timeout   = err_q;
`else
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_conf_regs_writer.sv
// -----------------------------------------------------------------------------
// tb_conf_regs_writer
//
// Drives host frames into conf_regs_writer (16-bit data, timeout of 8 cycles
// when the timeout build is selected) through an upstream byte source that
// obeys the rx_rdy/rx_ack handshake, and answers SI writes with a register
// bank whose ack delay is chosen per frame. Expected writes are queued when a
// frame is sent; a monitor pops them as register_rdy rises and checks
// address, data, handshake counts, write length, busy and err_timeout.
// -----------------------------------------------------------------------------
module tb_conf_regs_writer;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int DB     = DW / 8;
    localparam int TB_TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          rx_ack;
    logic [AW-1:0] register_addr;
    logic [DW-1:0] register_data;
    logic          register_rdy;
    logic          register_ack;
    logic          busy;
    logic          err_timeout;

    conf_regs_writer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TB_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .rx_ack       (rx_ack),
        .register_addr(register_addr),
        .register_data(register_data),
        .register_rdy (register_rdy),
        .register_ack (register_ack),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cycles;   // expected register_rdy high time
        bit            timeout;  // write is expected to be abandoned
    } exp_t;

    exp_t sb[$];
    int   delay_q[$];            // bank ack delay per write, -1 = never ack

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ack"},       rx_ack,        0);
        check({tag, "_addr"},         register_addr, 0);
        check({tag, "_data"},         register_data, 0);
        check({tag, "_rdy"},          register_rdy,  0);
        check({tag, "_busy"},         busy,          0);
        check({tag, "_err_timeout"},  err_timeout,   0);
    endtask

    // -------------------------------------------------------------------------
    // Upstream byte source
    // -------------------------------------------------------------------------
    // Presents a byte and returns on the negedge where rx_ack is seen, so the
    // caller can present the next byte before the following edge.
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rx_ack_wait: got no rx_ack expected one within 300 cycles for byte %0h", b);
        end
    endtask

    // One frame: address byte then data bytes MSB first. hold=1 leaves
    // rx_rdy high so the next frame's address byte waits through the write.
    task automatic send_frame(input logic [7:0] addr, input logic [DW-1:0] data,
                              input int dly, input int gap_max, input bit hold);
        exp_t e;
        send_byte(addr);
        for (int i = 0; i < DB; i++) begin
            int k;
            k = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (k > 0) begin
                rx_rdy = 1'b0;
                repeat (k) @(negedge clk);
            end
            send_byte(8'(data >> (8 * (DB - 1 - i))));
        end
        e.addr    = addr[AW-1:0];
        e.data    = data;
        e.timeout = (dly < 0);
        e.cycles  = (dly < 0) ? TB_TMO : dly + 1;
        sb.push_back(e);
        delay_q.push_back(dly);
        if (!hold) rx_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy && !register_rdy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=%0b rdy=%0b pending=%0d expected idle", busy, register_rdy, sb.size());
        end
    endtask

    // -------------------------------------------------------------------------
    // Register bank: acks after the frame's chosen number of rdy cycles
    // -------------------------------------------------------------------------
    bit active = 0;
    int dly    = 0;
    int cnt    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            active       = 0;
            cnt          = 0;
            register_ack = 1'b0;
        end else begin
            if (!active && register_rdy) begin
                active = 1;
                cnt    = 0;
                dly    = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            end
            if (active) begin
                if (register_ack) begin
                    register_ack = 1'b0;
                    active       = 0;
                end else if (!register_rdy) begin
                    active = 0;
                end else if (dly >= 0 && cnt == dly) begin
                    register_ack = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    bit   prev_rdy = 0;
    bit   prev_ack = 0;
    int   acks     = 0;
    int   high     = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst) begin
            prev_rdy = 0;
            prev_ack = 0;
            acks     = 0;
            high     = 0;
        end else begin
            if (rx_ack) begin
                check("rx_ack_back_to_back", prev_ack, 0);
                check("rx_ack_during_write", register_rdy, 0);
                check("busy_after_byte", busy, 1);
                acks++;
            end

            if (register_rdy && !prev_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", register_addr, register_data);
                    cur.addr    = register_addr;
                    cur.data    = register_data;
                    cur.cycles  = 0;
                    cur.timeout = 0;
                end else begin
                    cur = sb.pop_front();
                    check("write_addr", register_addr, cur.addr);
                    check("write_data", register_data, cur.data);
                    check("rx_ack_count", acks, DB + 1);
                end
                acks = 0;
                high = 0;
            end

            if (register_rdy) begin
                high++;
                check("busy_during_write", busy, 1);
                if (prev_rdy) begin
                    check("addr_stable", register_addr, cur.addr);
                    check("data_stable", register_data, cur.data);
                end
            end

            if (!register_rdy && prev_rdy) begin
                check("rdy_high_cycles", high, cur.cycles);
                check("err_timeout_at_end", err_timeout, cur.timeout);
                check("busy_after_write", busy, 0);
                check("rx_ack_at_rdy_fall", rx_ack, 0);
            end else if (err_timeout) begin
                check("err_timeout_spurious", err_timeout, 0);
            end

            prev_rdy = register_rdy;
            prev_ack = rx_ack;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst          = 1'b0;
        rx_rdy       = 1'b0;
        rx_data      = 8'h00;
        register_ack = 1'b0;

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Basic frame, ack one cycle after rdy.
        send_frame(8'h03, 16'hA55A, 1, 0, 0);
        wait_idle();
        check("idle_busy", busy, 0);

        // Big-endian assembly.
        send_frame(8'h01, 16'h1234, 1, 0, 0);
        wait_idle();

        // Slow ack with the next address byte waiting on rx_rdy throughout.
        send_frame(8'h20, 16'hC0DE, 10, 0, 1);
        send_frame(8'h21, 16'h0FF0, 0, 0, 0);
        wait_idle();

        // Reset after the address byte only.
        send_byte(8'h09);
        rx_rdy = 1'b0;
        #2 rst = 1'b0;
        #1 check_outputs_zero("reset_mid_frame");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        send_frame(8'h05, 16'h7766, 0, 0, 0);
        wait_idle();

        // Reset while register_rdy is high.
        send_frame(8'h06, 16'h1111, 50, 0, 0);
        for (int i = 0; i < 20 && !register_rdy; i++) @(negedge clk);
        check("rdy_before_reset", register_rdy, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_outputs_zero("reset_mid_write");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        delay_q.delete();

        // Stray ack while idle must not start or end anything.
        register_ack = 1'b1;
        @(negedge clk);
        register_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_rdy", register_rdy, 0);
        check("stray_ack_busy", busy, 0);
        send_frame(8'h07, 16'hABCD, 3, 0, 0);
        wait_idle();

`ifdef CONF_REGS_WRITER_TIMEOUT_EN
        // No ack ever: write abandoned after TB_TMO rdy cycles.
        send_frame(8'h44, 16'hBEEF, -1, 0, 0);
        wait_idle();
        send_frame(8'h45, 16'h0102, 2, 0, 0);
        wait_idle();
`endif

        // Randomized frames: random contents, inter-byte gaps, ack delays
        // and back-to-back frames held on rx_rdy.
        for (int f = 0; f < 24; f++) begin
            send_frame(8'($urandom), 16'($urandom), int'($urandom_range(0, 6)),
                       2, (f != 23) && ($urandom_range(0, 1) == 1));
        end
        wait_idle();

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
